// File: rtl/alu_multicycle.sv
// Handshaked ALU: ADD/SUB/ACC/AND/OR in one cycle, MUL/DIV/AVG3 on a shared shift/add datapath (ALU_MC_FAST_MUL_EN makes MUL single-cycle).
// Latency: accept at edge N gives out_valid at N+1 (single-cycle) or N+BITS+1 (iterative); one op in flight, in_ready only in IDLE, result held until out_ready.
module alu_multicycle #(
   parameter int BITS     = 32,
   parameter int ACC_BITS = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] SrcAE,
   input  logic [BITS-1:0] SrcBE,
   input  logic [2:0]      ALUControlE,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] ALUResultE,
   output logic [3:0]      ALUFlags
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_ACC  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_DIV  = 3'b110;
   localparam logic [2:0] OP_AVG3 = 3'b111;

   localparam int             CW       = $clog2(BITS);
   localparam logic [CW-1:0]  CNT_LAST = CW'(BITS - 1);

   logic [1:0]      r_state;
   logic            r_rdy_en;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_op;
   logic [BITS-1:0] r_a;
   logic [BITS-1:0] r_b;
   logic [BITS-1:0] r_acc;
   logic [BITS-1:0] r_result;
   logic [3:0]      r_flags;

   logic            w_accept;
   logic            w_iter_op;
   logic [BITS:0]   w_add;
   logic [BITS:0]   w_sub;
   logic [BITS:0]   w_acc;
   logic [BITS-1:0] w_acc_mask;
   logic [BITS-1:0] w_accb;
   logic [9:0]      w_avg_sum;
   logic [BITS-1:0] w_avg_ext;
   logic [BITS-1:0] w_sc_res;
   logic            w_sc_c;
   logic            w_sc_v;
   logic [BITS:0]   w_rem_sh;
   logic            w_qbit;
   logic [BITS-1:0] w_rem_sub;
   logic [BITS-1:0] w_rem_nx;
   logic [BITS-1:0] w_mul_nx;
   logic [BITS-1:0] w_it_res;
   logic            w_it_v;

   assign in_ready   = r_rdy_en && (r_state == ST_IDLE);
   assign out_valid  = (r_state == ST_DONE);
   assign ALUResultE = r_result;
   assign ALUFlags   = r_flags;
   assign w_accept   = in_valid && in_ready;

`ifdef ALU_MC_FAST_MUL_EN
   assign w_iter_op = (ALUControlE == OP_DIV) || (ALUControlE == OP_AVG3);
`else
   assign w_iter_op = (ALUControlE == OP_DIV) || (ALUControlE == OP_AVG3) || (ALUControlE == OP_MUL);
`endif

   assign w_add      = {1'b0, SrcAE} + {1'b0, SrcBE};
   assign w_sub      = {1'b0, SrcAE} - {1'b0, SrcBE};
   assign w_acc_mask = {BITS{1'b1}} >> (BITS - ACC_BITS);
   assign w_accb     = SrcBE & w_acc_mask;
   assign w_acc      = {1'b0, SrcAE} + {1'b0, w_accb};
   assign w_avg_sum  = {2'b00, SrcAE[7:0]} + {2'b00, SrcAE[15:8]} + {2'b00, SrcAE[23:16]};
   assign w_avg_ext  = {{(BITS-10){1'b0}}, w_avg_sum};

   always_comb begin
      w_sc_res = '0;
      w_sc_c   = 1'b0;
      w_sc_v   = 1'b0;
      case (ALUControlE)
         OP_ADD: begin
            w_sc_res = w_add[BITS-1:0];
            w_sc_c   = w_add[BITS];
            w_sc_v   = (SrcAE[BITS-1] == SrcBE[BITS-1]) && (w_add[BITS-1] != SrcAE[BITS-1]);
         end
         OP_SUB: begin
            w_sc_res = w_sub[BITS-1:0];
            w_sc_c   = ~w_sub[BITS];
            w_sc_v   = (SrcAE[BITS-1] != SrcBE[BITS-1]) && (w_sub[BITS-1] != SrcAE[BITS-1]);
         end
         OP_ACC: begin
            w_sc_res = w_acc[BITS-1:0];
            w_sc_c   = w_acc[BITS];
         end
         OP_AND: w_sc_res = SrcAE & SrcBE;
         OP_OR:  w_sc_res = SrcAE | SrcBE;
`ifdef ALU_MC_FAST_MUL_EN
         OP_MUL: w_sc_res = SrcAE * SrcBE;
`endif
         default: ;
      endcase
   end

   // r_a doubles as multiplicand (MUL) and as dividend/quotient shift register (DIV/AVG3):
   // dividend bits leave at the top while quotient bits enter at the bottom.
   assign w_rem_sh  = {r_acc, r_a[BITS-1]};
   assign w_qbit    = (w_rem_sh >= {1'b0, r_b});
   assign w_rem_sub = w_rem_sh[BITS-1:0] - r_b;
   assign w_rem_nx  = w_qbit ? w_rem_sub : w_rem_sh[BITS-1:0];
   assign w_mul_nx  = r_acc + (r_b[0] ? r_a : '0);
   assign w_it_res  = (r_op == OP_MUL) ? w_mul_nx : {r_a[BITS-2:0], w_qbit};
   assign w_it_v    = (r_op == OP_DIV) && (r_b == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_rdy_en <= 1'b0;
         r_cnt    <= '0;
         r_op     <= OP_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_flags  <= 4'b0000;
      end else begin
         r_rdy_en <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op  <= ALUControlE;
                  r_cnt <= '0;
                  if (w_iter_op) begin
                     r_state <= ST_BUSY;
                     r_a     <= (ALUControlE == OP_AVG3) ? w_avg_ext : SrcAE;
                     r_b     <= (ALUControlE == OP_AVG3) ? BITS'(3) : SrcBE;
                     r_acc   <= '0;
                  end else begin
                     r_state  <= ST_DONE;
                     r_result <= w_sc_res;
                     r_flags  <= {w_sc_res[BITS-1], (w_sc_res == '0), w_sc_c, w_sc_v};
                  end
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_op == OP_MUL) begin
                  r_a   <= {r_a[BITS-2:0], 1'b0};
                  r_b   <= {1'b0, r_b[BITS-1:1]};
                  r_acc <= w_mul_nx;
               end else begin
                  r_a   <= {r_a[BITS-2:0], w_qbit};
                  r_acc <= w_rem_nx;
               end
               if (r_cnt == CNT_LAST) begin
                  r_state  <= ST_DONE;
                  r_cnt    <= '0;
                  r_result <= w_it_res;
                  r_flags  <= {w_it_res[BITS-1], (w_it_res == '0), 1'b0, w_it_v};
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
